// File: rtl/mips789_defs.sv
// Shared definitions for the RF-stage hazard/forwarding scheduler.
//   fw_sel_e   : forward-select codes driven into the RF forwarding muxes
//   md_state_e : mul/div occupancy FSM encoding
//   ex_slot_t  : destination bookkeeping for the instruction in EX
//   mem_slot_t : destination bookkeeping for the instruction in MEM
package mips789_defs;

  typedef enum logic [2:0] {
    FW_RF  = 3'd0,
    FW_ALU = 3'd1,
    FW_MEM = 3'd2
  } fw_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       load;
  } ex_slot_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } mem_slot_t;

endpackage

// File: rtl/rf_hazard_ctl_if.sv
// RF-stage <-> hazard controller signal bundle.
//   Request side (from RF): source indices/uses, destination, load and mul/div flags.
//   Response side (to RF) : rs/rt forward selects, stall, bubble, mul/div busy.
// modport master: the RF stage (drives requests, consumes responses).
// modport slave : the hazard controller.
interface rf_hazard_ctl_if;
  logic [4:0] rs_n_i;
  logic [4:0] rt_n_i;
  logic       rs_use_i;
  logic       rt_use_i;
  logic [4:0] rd_i;
  logic       rd_we_i;
  logic       is_load_i;
  logic       md_start_i;
  logic       md_use_i;
  logic [2:0] fw_cmp_rs_o;
  logic [2:0] fw_cmp_rt_o;
  logic       stall_o;
  logic       bubble_o;
  logic       md_busy_o;

  modport master (
    output rs_n_i, rt_n_i, rs_use_i, rt_use_i, rd_i, rd_we_i, is_load_i,
           md_start_i, md_use_i,
    input  fw_cmp_rs_o, fw_cmp_rt_o, stall_o, bubble_o, md_busy_o
  );

  modport slave (
    input  rs_n_i, rt_n_i, rs_use_i, rt_use_i, rd_i, rd_we_i, is_load_i,
           md_start_i, md_use_i,
    output fw_cmp_rs_o, fw_cmp_rt_o, stall_o, bubble_o, md_busy_o
  );
endinterface

// File: rtl/fw_sel.sv
// Per-source forwarding comparator (purely combinational).
//   idx      : source register index read by the RF instruction
//   use_src  : RF instruction actually reads this source
//   ex_slot  : destination info of the instruction in EX
//   mem_slot : destination info of the instruction in MEM
//   code     : forward select (FW_RF / FW_ALU / FW_MEM)
//   load_use : source depends on a load still in EX
module fw_sel
  import mips789_defs::*;
(
  input  logic [4:0] idx,
  input  logic       use_src,
  input  ex_slot_t   ex_slot,
  input  mem_slot_t  mem_slot,
  output logic [2:0] code,
  output logic       load_use
);

  always_comb begin
    code     = FW_RF;
    load_use = 1'b0;
    // r0 is hardwired zero, so it never forwards or stalls regardless of slot contents.
    if (!use_src || idx == 5'd0) begin
      code = FW_RF;
    end else if (ex_slot.we && ex_slot.rd == idx) begin
      // A load result is not available until MEM; stall one cycle and take it from there.
      if (ex_slot.load) begin
        load_use = 1'b1;
      end else begin
        code = FW_ALU;
      end
    end else if (mem_slot.we && mem_slot.rd == idx) begin
      code = FW_MEM;
    end
  end

endmodule

// File: rtl/rf_hazard_ctl.sv
// Hazard and forwarding scheduler for the register-fetch stage.
//   clk   : system clock, rising edge
//   rst_i : asynchronous active-low reset
//   pause : global pipeline freeze, all state holds
//   rf    : RF-stage bundle (slave side): source/destination info in,
//           forward selects, stall, bubble and mul/div busy out
// Parameters:
//   MD_LAT : cycles a mul/div occupies HI/LO after acceptance (1..63)
//   CW     : countdown width, 2**CW must exceed MD_LAT
module rf_hazard_ctl
  import mips789_defs::*;
#(
  parameter int unsigned MD_LAT = 33,
  parameter int unsigned CW     = 6
) (
  input logic           clk,
  input logic           rst_i,
  input logic           pause,
  rf_hazard_ctl_if.slave rf
);

  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q, mem_d;
  md_state_e md_q, md_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0] fw_rs, fw_rt;
  logic       lu_rs, lu_rt;
  logic       md_busy, md_hz, stall;

  fw_sel u_fw_rs (
    .idx      (rf.rs_n_i),
    .use_src  (rf.rs_use_i),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .code     (fw_rs),
    .load_use (lu_rs)
  );

  fw_sel u_fw_rt (
    .idx      (rf.rt_n_i),
    .use_src  (rf.rt_use_i),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .code     (fw_rt),
    .load_use (lu_rt)
  );

  assign md_busy = (md_q == MD_BUSY);
  assign md_hz   = (rf.md_use_i | rf.md_start_i) & md_busy;
  assign stall   = lu_rs | lu_rt | md_hz;

  assign rf.fw_cmp_rs_o = fw_rs;
  assign rf.fw_cmp_rt_o = fw_rt;
  assign rf.stall_o     = stall;
  // Under pause nothing moves, so no bubble is injected even while a hazard is pending.
  assign rf.bubble_o    = stall & ~pause;
  assign rf.md_busy_o   = md_busy;

  // Pipeline slot tracking: EX takes a bubble while RF is held, MEM always follows EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!pause) begin
      mem_d.rd = ex_q.rd;
      mem_d.we = ex_q.we;
      if (stall) begin
        ex_d = '0;
      end else begin
        ex_d.rd   = rf.rd_i;
        ex_d.we   = rf.rd_we_i;
        ex_d.load = rf.is_load_i;
      end
    end
  end

  // Mul/div occupancy: counter loads MD_LAT-1 so BUSY spans exactly MD_LAT unpaused cycles.
  always_comb begin
    md_d  = md_q;
    cnt_d = cnt_q;
    if (!pause) begin
      unique case (md_q)
        MD_IDLE: begin
          if (rf.md_start_i && !stall) begin
            md_d  = MD_BUSY;
            cnt_d = CW'(MD_LAT - 1);
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) begin
            md_d = MD_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      md_q  <= MD_IDLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      md_q  <= md_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rf_hazard_ctl.sv
// Directed self-checking bench for rf_hazard_ctl (MD_LAT=4, CW=3).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_rf_hazard_ctl;

  logic clk;
  logic rst_i;
  logic pause;
  int   passed;
  int   failed;
  int   total;

  rf_hazard_ctl_if bus ();

  rf_hazard_ctl #(
    .MD_LAT (4),
    .CW     (3)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .pause (pause),
    .rf    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] rd, input logic we,
                       input logic ld, input logic mds, input logic mdu);
    bus.rs_n_i     = rs;
    bus.rs_use_i   = rsu;
    bus.rt_n_i     = rt;
    bus.rt_use_i   = rtu;
    bus.rd_i       = rd;
    bus.rd_we_i    = we;
    bus.is_load_i  = ld;
    bus.md_start_i = mds;
    bus.md_use_i   = mdu;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    pause  = 1'b0;
    rst_i  = 1'b0;

    // Reset: even with sources requested and md_start high, outputs are all 0.
    drive(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #3;
    check("rst_fw_rs", 8'(bus.fw_cmp_rs_o), 8'd0);
    check("rst_fw_rt", 8'(bus.fw_cmp_rt_o), 8'd0);
    check("rst_stall", 8'(bus.stall_o), 8'd0);
    check("rst_bubble", 8'(bus.bubble_o), 8'd0);
    check("rst_busy", 8'(bus.md_busy_o), 8'd0);
    @(negedge clk);
    rst_i = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back dependency on r5: ALU, then MEM, then register file.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("b2b_prod_stall", 8'(bus.stall_o), 8'd0);
    @(negedge clk);
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("b2b_fw_alu", 8'(bus.fw_cmp_rs_o), 8'd1);
    check("b2b_stall0", 8'(bus.stall_o), 8'd0);
    @(negedge clk);
    #1 check("b2b_fw_mem", 8'(bus.fw_cmp_rs_o), 8'd2);
    check("b2b_stall1", 8'(bus.stall_o), 8'd0);
    @(negedge clk);
    #1 check("b2b_fw_rf", 8'(bus.fw_cmp_rs_o), 8'd0);
    check("b2b_stall2", 8'(bus.stall_o), 8'd0);

    // Load-use on r8 through rt: one stall cycle, then MEM forward.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 check("lu_load_stall", 8'(bus.stall_o), 8'd0);
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("lu_stall", 8'(bus.stall_o), 8'd1);
    check("lu_bubble", 8'(bus.bubble_o), 8'd1);
    check("lu_fw_rt_rf", 8'(bus.fw_cmp_rt_o), 8'd0);
    @(negedge clk);
    #1 check("lu_fw_rt_mem", 8'(bus.fw_cmp_rt_o), 8'd2);
    check("lu_release", 8'(bus.stall_o), 8'd0);
    check("lu_bubble_off", 8'(bus.bubble_o), 8'd0);

    // Mul/div then mfhi: busy and stalled for 4 cycles, released on the 5th.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("md_accept_stall", 8'(bus.stall_o), 8'd0);
    check("md_accept_busy", 8'(bus.md_busy_o), 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 check($sformatf("md_use_busy%0d", i), 8'(bus.md_busy_o), 8'd1);
      check($sformatf("md_use_stall%0d", i), 8'(bus.stall_o), 8'd1);
      check($sformatf("md_use_bubble%0d", i), 8'(bus.bubble_o), 8'd1);
    end
    @(negedge clk);
    #1 check("md_use_rel_busy", 8'(bus.md_busy_o), 8'd0);
    check("md_use_rel_stall", 8'(bus.stall_o), 8'd0);

    // Second start while busy: stalls for the whole BUSY window, accepted afterwards.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("md2_first_stall", 8'(bus.stall_o), 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check($sformatf("md2_wait_stall%0d", i), 8'(bus.stall_o), 8'd1);
    end
    @(negedge clk);
    #1 check("md2_accept_stall", 8'(bus.stall_o), 8'd0);
    check("md2_accept_busy", 8'(bus.md_busy_o), 8'd0);

    // Reset mid-BUSY with EX holding a live r9 write: outputs clear before the next edge.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("rstmid_busy_pre", 8'(bus.md_busy_o), 8'd1);
    @(negedge clk);
    drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("rstmid_fw_pre", 8'(bus.fw_cmp_rs_o), 8'd1);
    check("rstmid_stall_pre", 8'(bus.stall_o), 8'd1);
    #1 rst_i = 1'b0;
    #1 check("rstmid_busy", 8'(bus.md_busy_o), 8'd0);
    check("rstmid_fw_rs", 8'(bus.fw_cmp_rs_o), 8'd0);
    check("rstmid_stall", 8'(bus.stall_o), 8'd0);
    @(negedge clk);
    rst_i = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause during BUSY freezes the counter: 2 paused + 4 running busy cycles.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("pmd_accept_busy", 8'(bus.md_busy_o), 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pause = 1'b1;
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check($sformatf("pmd_paused_busy%0d", i), 8'(bus.md_busy_o), 8'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pause = 1'b0;
      #1 check($sformatf("pmd_run_busy%0d", i), 8'(bus.md_busy_o), 8'd1);
    end
    @(negedge clk);
    #1 check("pmd_done_busy", 8'(bus.md_busy_o), 8'd0);

    // Pause over a load-use stall: stall held, no bubble, resolves one cycle after pause drops.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 check("plu_load_stall", 8'(bus.stall_o), 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pause = 1'b1;
      drive(5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check($sformatf("plu_stall%0d", i), 8'(bus.stall_o), 8'd1);
      check($sformatf("plu_bubble%0d", i), 8'(bus.bubble_o), 8'd0);
    end
    @(negedge clk);
    pause = 1'b0;
    #1 check("plu_unpause_stall", 8'(bus.stall_o), 8'd1);
    check("plu_unpause_bubble", 8'(bus.bubble_o), 8'd1);
    @(negedge clk);
    #1 check("plu_release", 8'(bus.stall_o), 8'd0);
    check("plu_fw_rt_mem", 8'(bus.fw_cmp_rt_o), 8'd2);

    // Register zero: a load targeting r0 in EX never forwards or stalls.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 check("r0_prod_stall", 8'(bus.stall_o), 8'd0);
    @(negedge clk);
    drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("r0_fw_rs", 8'(bus.fw_cmp_rs_o), 8'd0);
    check("r0_fw_rt", 8'(bus.fw_cmp_rt_o), 8'd0);
    check("r0_stall", 8'(bus.stall_o), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_hazard_ctl.md
Name: rf_hazard_ctl

Overview:
- Hazard and forwarding scheduler for the register-fetch stage.
- Tracks destination registers of the instructions now in EX and MEM, and drives the rs/rt forward-select codes into the RF forwarding muxes.
- Detects load-use and multiply/divide structural hazards, then stalls the RF stage and injects a bubble into EX.
- Sits beside rf_stage; its outputs feed fw_cmp_rs, fw_cmp_rt and the RF hold/EX clear paths.

Parameters:
- MD_LAT, 33, cycles a mul/div occupies HI/LO after acceptance (legal range 1..63).
- CW, 6, width of the mul/div countdown counter; must satisfy 2**CW > MD_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- pause  in  1  global pipeline freeze; all state holds.
- rs_n_i  in  5  rs index of the instruction in RF.
- rt_n_i  in  5  rt index of the instruction in RF.
- rs_use_i  in  1  RF instruction reads rs.
- rt_use_i  in  1  RF instruction reads rt.
- rd_i  in  5  destination index of the RF instruction.
- rd_we_i  in  1  RF instruction writes rd.
- is_load_i  in  1  RF instruction is a load.
- md_start_i  in  1  RF instruction starts a mul/div.
- md_use_i  in  1  RF instruction reads HI/LO (mfhi/mflo).
- fw_cmp_rs_o  out  3  rs forward select.
- fw_cmp_rt_o  out  3  rt forward select.
- stall_o  out  1  hold the RF instruction register and PC.
- bubble_o  out  1  clear the RA-to-EX control (insert NOP).
- md_busy_o  out  1  mul/div unit occupied.

Behaviour:
- State: EX slot {rd[4:0], we, load} and MEM slot {rd[4:0], we}, plus the mul/div FSM and counter.
- Reset (rst_i=0, asynchronous): both slots have we=0, load=0, rd=0; FSM in MD_IDLE; count=0. All outputs read 0.
- Forward select per source s (rs or rt), combinational, in priority order:
  - s_use=0 or index=0 -> FW_RF.
  - EX.we and EX.rd==index and !EX.load -> FW_ALU.
  - EX.we and EX.rd==index and EX.load -> FW_RF, and a load-use hazard is raised.
  - MEM.we and MEM.rd==index -> FW_MEM.
  - Otherwise -> FW_RF. The register file write-through covers WB.
- Stall sources:
  - stall_o = load_use | md_hz.
  - md_hz = (md_use_i | md_start_i) & md_busy_o.
  - bubble_o = stall_o & !pause.
- Slot update on rising clk:
  - pause=1: hold everything, including the counter.
  - stall_o=1: EX <= bubble (we=0, load=0); MEM <= EX.
  - Otherwise: EX <= {rd_i, rd_we_i, is_load_i}; MEM <= EX.
- Mul/div FSM:
  - MD_IDLE -> MD_BUSY when md_start_i & !stall_o & !pause. Counter loads MD_LAT-1.
  - MD_BUSY with pause=0: if count==0 go to MD_IDLE, else count--.
  - md_busy_o = (state==MD_BUSY).
  - MD_LAT=1: BUSY lasts exactly one cycle.
- Boundary cases:
  - Load-use and md hazard in the same cycle: a single stall; EX gets one bubble per stalled cycle.
  - A load-use stall lasts exactly one cycle, because the load advances to MEM and is then forwarded as FW_MEM.
  - md_start_i while busy: stalls until the cycle after BUSY exits, then is accepted.
  - pause together with a hazard: stall_o stays asserted, bubble_o is 0, and no state changes.
  - rd=0 in either slot never matches a used source (index 0 resolves first).
  - Reset mid-BUSY: returns to MD_IDLE immediately.

Decomposition:
- Shared package mips789_defs holds the forward codes and FSM encodings:
  - FW_RF=3'd0, FW_ALU=3'd1, FW_MEM=3'd2.
  - MD_IDLE=1'b0, MD_BUSY=1'b1.
- One natural sub-module: fw_sel. It is the combinational per-source comparator (index, use, EX slot, MEM slot -> code, load_use) and is instantiated twice, once for rs and once for rt.

Test Plan:
- Back-to-back dependency: RF writes r5 (rd_we_i=1), next instruction reads rs=5 with rs_use_i=1 -> fw_cmp_rs_o=1 that cycle; one instruction later -> 2; two later -> 0; stall_o stays 0 throughout.
- Load-use: load to r8, then rt=8 with rt_use_i=1 -> stall_o=1 and bubble_o=1 for exactly one cycle, then fw_cmp_rt_o=2 and stall_o=0.
- Mul/div: MD_LAT=4, md_start_i accepted, then md_use_i asserted -> md_busy_o high 4 cycles, stall_o high 4 cycles, released on cycle 5.
- Pause: assert pause for 3 cycles during a load-use stall -> slots and counter frozen, bubble_o=0; stall resolves one cycle after pause drops.
- Reset mid-operation: pull rst_i low asynchronously while MD_BUSY with EX.we=1 -> md_busy_o=0, fw codes=0 and stall_o=0 before the next clk edge.
- Register zero: EX writes r0, RF reads rs=0 -> fw_cmp_rs_o=0 and no stall, even with is_load.
